// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch with PC-tagged in-flight requests, in-order
// response queue with credit-based issue, and the IF/ID register for decode.
module if_fetch_queue #(
  parameter int          DEPTH     = 2,
  parameter int          MAX_OUT   = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_stall,
  input  logic        flush,
  output logic        stall_PC,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
);
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam int QW = $clog2(DEPTH) + 1;
  localparam int QP = $clog2(DEPTH);
  localparam int TP = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  logic [OW-1:0] out_q, out_d, drop_q, drop_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [QP-1:0] qwr_q, qwr_d, qrd_q, qrd_d;
  logic [TP-1:0] twr_q, twr_d, trd_q, trd_d;
  logic [31:0]   tag_q [MAX_OUT];
  logic [31:0]   qpc_q [DEPTH];
  logic [31:0]   qins_q [DEPTH];
  logic          valid_q, valid_d;
  logic [31:0]   pc_q, pc_d, instr_q, instr_d;
  logic          req_fire, rsp_fire, live, load, q_ne, q_pop, q_push, bypass;
  // issue only while every possible response still has a guaranteed queue slot
  assign imem_req_valid = reset & ~flush & (drop_q == '0) & (out_q < OW'(MAX_OUT))
                        & (int'(qcnt_q) + int'(out_q) < DEPTH);
  assign imem_addr = pc_in;
  assign req_fire  = imem_req_valid & imem_req_ready;
  assign stall_PC  = ~req_fire;
  assign rsp_fire  = imem_rsp_valid & (out_q != '0);
  assign live      = rsp_fire & ~flush & (drop_q == '0);
  assign load      = ~id_stall | ~valid_q;
  assign q_ne      = qcnt_q != '0;
  assign q_pop     = load & q_ne & ~flush;
  assign bypass    = load & ~q_ne & live;
  assign q_push    = live & ~bypass;
  assign out_d  = out_q + OW'(req_fire) - OW'(rsp_fire);
  assign drop_d = flush ? out_q - OW'(rsp_fire) : drop_q - OW'(rsp_fire && drop_q != '0);
  assign qcnt_d = flush ? '0 : qcnt_q + QW'(q_push) - QW'(q_pop);
  assign qwr_d  = flush ? '0 : qwr_q + QP'(q_push);
  assign qrd_d  = flush ? '0 : qrd_q + QP'(q_pop);
  assign twr_d  = !req_fire ? twr_q : (twr_q == TP'(MAX_OUT - 1)) ? '0 : twr_q + 1'b1;
  assign trd_d  = !rsp_fire ? trd_q : (trd_q == TP'(MAX_OUT - 1)) ? '0 : trd_q + 1'b1;
  assign valid_d = q_pop | bypass | (valid_q & ~flush & ~load);
  assign pc_d    = q_pop ? qpc_q[qrd_q] : bypass ? tag_q[trd_q] : pc_q;
  assign instr_d = q_pop ? qins_q[qrd_q] : bypass ? imem_rsp_data
                 : (flush | load) ? NOP_INSTR : instr_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      drop_q  <= '0;
      qcnt_q  <= '0;
      qwr_q   <= '0;
      qrd_q   <= '0;
      twr_q   <= '0;
      trd_q   <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      out_q   <= out_d;
      drop_q  <= drop_d;
      qcnt_q  <= qcnt_d;
      qwr_q   <= qwr_d;
      qrd_q   <= qrd_d;
      twr_q   <= twr_d;
      trd_q   <= trd_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (req_fire) tag_q[twr_q] <= pc_in;
    if (q_push) begin
      qpc_q[qwr_q]  <= tag_q[trd_q];
      qins_q[qwr_q] <= imem_rsp_data;
    end
  end
  assign if_id_valid = valid_q;
  assign if_id_pc    = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc_q + 32'd4;
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Issues instruction-memory reads at the current PC and tags each in-flight request with its PC.
- Buffers returned instructions in a small in-order queue and drives the IF/ID pipeline register consumed by decode.
- Generates stall_PC back to the PC register, so the PC advances only when a fetch request is accepted.

Parameters:
- DEPTH, 2, instruction queue depth; power of two, ≥2.
- MAX_OUT, 2, maximum outstanding imem requests; ≤DEPTH.
- NOP_INSTR, 32'h00000013, bubble instruction presented when IF/ID is invalid.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- pc_in  input  32  current PC from PC register.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  imem accepts request this cycle.
- imem_addr  output  32  request address, equals pc_in.
- imem_rsp_valid  input  1  response valid; responses in request order, ≥1 cycle after accept.
- imem_rsp_data  input  32  fetched instruction.
- id_stall  input  1  decode cannot accept a new IF/ID value.
- flush  input  1  redirect (branch/jump/trap); kill all younger fetch state.
- stall_PC  output  1  to PC register: hold PC.
- if_id_valid  output  1  IF/ID holds a live instruction.
- if_id_pc  output  32  PC of IF/ID instruction.
- if_id_instr  output  32  instruction; NOP_INSTR when invalid.
- if_id_pc4  output  32  if_id_pc + 4, mod 2^32.

Behaviour:
Reset (reset==0, asynchronous, effective immediately):
- Queue and tag FIFO empty; outstanding=0; drop_cnt=0.
- if_id_valid=0, if_id_pc=0, if_id_pc4=4, if_id_instr=NOP_INSTR.
- imem_req_valid=0, stall_PC=1.

Issue:
- imem_req_valid = reset & ~flush & (drop_cnt==0) & (outstanding<MAX_OUT) & (q_count+outstanding<DEPTH).
- req_fire = imem_req_valid & imem_req_ready.
- On req_fire, push pc_in into the tag FIFO and increment outstanding.
- stall_PC = ~req_fire (combinational).
- Credit rule: every accepted response is guaranteed a queue slot; queue overflow is impossible.

Response:
- rsp_fire = imem_rsp_valid & (outstanding>0). imem_rsp_valid with outstanding==0 is ignored; this is an assertion error in the bench.
- On rsp_fire, pop the tag FIFO and decrement outstanding.
- If drop_cnt>0 or flush: discard the response; decrement drop_cnt if it is >0.
- Otherwise: push {tag, data} into the queue.

IF/ID load (when ~id_stall | ~if_id_valid):
- Queue non-empty: load the head and pop it.
- Else, bypass: queue empty and a live response arrives: load the response directly. Latency from response to IF/ID valid is 1 cycle.
- Else: if_id_valid←0, if_id_instr←NOP_INSTR.
- With id_stall & if_id_valid, IF/ID holds.

Flush (single-cycle, highest priority after reset):
- Queue cleared; if_id_valid←0; if_id_instr←NOP_INSTR.
- No request issued that cycle.
- drop_cnt ← outstanding − rsp_fire. outstanding is tracked normally; tag entries of dropped requests pop on their responses.
- flush and id_stall together: flush wins.

Counters:
- outstanding and drop_cnt use clog2(MAX_OUT)+1 bits.
- q_count uses clog2(DEPTH)+1 bits.
- Pointers wrap modulo DEPTH / MAX_OUT.
- Simultaneous push and pop on a full queue is legal; count is unchanged.

Test Plan:
1. Reset: hold reset=0 for 3 cycles while imem_rsp_valid toggles -> if_id_valid=0, if_id_instr=32'h00000013, imem_req_valid=0, stall_PC=1 throughout; deassert reset -> first request at pc_in=32'h00400028 in the next cycle.
2. Streaming: imem_req_ready=1, 1-cycle response latency, pc_in 0x00400028, 0x0040002C, 0x00400030 -> IF/ID shows the three PCs and instructions in order, one per cycle, starting 2 cycles after the first accept; if_id_pc4=0x0040002C for the first; stall_PC=0 each accept cycle.
3. Decode backpressure: id_stall=1 for 4 cycles during streaming -> IF/ID holds; queue fills to 2; imem_req_valid drops; stall_PC=1; after release, instructions resume with no loss or duplication.
4. Flush with 2 outstanding: flush pulse, then both responses return -> both discarded; drop_cnt goes 2→1→0; no issue until drop_cnt=0; first instruction after flush carries the new pc_in (e.g. 0x00400100).
5. Flush coincident with a response -> that response is discarded; drop_cnt=outstanding−1; if_id_valid=0 next cycle.
6. Reset mid-operation: assert reset=0 with 2 queued and 1 outstanding -> all outputs return to reset values immediately; the late response after reset release is ignored; normal fetch resumes.
